// File: rtl/wb_pkg.sv
// Shared decode constants and status codes for the writeback arbiter.
package wb_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;

  localparam logic [2:0] ST_ADD   = 3'd1;
  localparam logic [2:0] ST_ADDI  = 3'd2;
  localparam logic [2:0] ST_SUB   = 3'd3;
  localparam logic [2:0] ST_MUL   = 3'd4;
  localparam logic [2:0] ST_DIV   = 3'd5;

  // Register-file write request at the default architectural widths.
  typedef struct packed {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_md_fifo.sv
// Synchronous FIFO for mult/div results; head is valid whenever count != 0.
module wb_md_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers are power-of-two sized, so wrap falls out of the adder.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: MW pipeline writes win the regfile port, queued mult/div
// results drain in idle cycles. Optional status redirects under WB_EXCEPTION_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MD_DEPTH   = 4,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mw_valid,
  input  logic [31:0]                 mw_insn,
  input  logic [DATA_W-1:0]           mw_o,
  input  logic [DATA_W-1:0]           mw_d,
  input  logic                        mw_ovf,
  input  logic                        md_valid,
  output logic                        md_ready,
  input  logic [REG_AW-1:0]           md_rd,
  input  logic [DATA_W-1:0]           md_result,
  input  logic                        md_exc,
  input  logic                        md_div,
  output logic                        ctrl_writeEnable,
  output logic [REG_AW-1:0]           ctrl_writeReg,
  output logic [DATA_W-1:0]           data_writeReg,
  output logic [$clog2(MD_DEPTH):0]   md_count
);
  localparam int CW = $clog2(MD_DEPTH) + 1;
`ifdef WB_EXCEPTION_EN
  localparam int EW = REG_AW + DATA_W + 2;
`else
  localparam int EW = REG_AW + DATA_W;
`endif

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] idx;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              pw, md_w;
  logic [4:0]        op, alu_op;
  logic [REG_AW-1:0] rd, head_rd;
  logic [EW-1:0]     wdata, head;
  logic              push, pop;
  logic              unused;

  assign op     = mw_insn[31:27];
  assign alu_op = mw_insn[6:2];
  assign rd     = REG_AW'(mw_insn[26:22]);
  assign unused = ^{mw_insn[21:7], mw_insn[1:0], mw_ovf, md_exc, md_div, alu_op};

  always_comb begin
    pw = '0;
    case (op)
      OP_RTYPE, OP_ADDI: begin pw.en = (rd != '0); pw.idx = rd; pw.data = mw_o; end
      OP_LW:             begin pw.en = (rd != '0); pw.idx = rd; pw.data = mw_d; end
      OP_JAL:            begin pw.en = 1'b1; pw.idx = REG_AW'(LINK_REG);   pw.data = mw_o; end
      OP_SETX:           begin pw.en = 1'b1; pw.idx = REG_AW'(STATUS_REG); pw.data = mw_o; end
      default: ;
    endcase
`ifdef WB_EXCEPTION_EN
    // Overflow redirects to the status register even when rd is r0.
    if (mw_ovf && (op == OP_ADDI ||
                   (op == OP_RTYPE && (alu_op == ALU_ADD || alu_op == ALU_SUB)))) begin
      pw.en   = 1'b1;
      pw.idx  = REG_AW'(STATUS_REG);
      pw.data = (op == OP_ADDI) ? DATA_W'(ST_ADDI) :
                (alu_op == ALU_SUB) ? DATA_W'(ST_SUB) : DATA_W'(ST_ADD);
    end
`endif
    pw.en = pw.en & mw_valid;
  end

  assign md_ready = (md_count < CW'(MD_DEPTH));
  assign push     = md_valid && md_ready;
  assign pop      = !pw.en && (md_count != '0);

`ifdef WB_EXCEPTION_EN
  assign wdata = {md_exc, md_div, md_rd, md_result};
`else
  assign wdata = {md_rd, md_result};
`endif

  wb_md_fifo #(.W(EW), .DEPTH(MD_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .count (md_count)
  );

  assign head_rd = head[DATA_W +: REG_AW];

  always_comb begin
    md_w.en   = (head_rd != '0);
    md_w.idx  = head_rd;
    md_w.data = head[DATA_W-1:0];
`ifdef WB_EXCEPTION_EN
    if (head[EW-1]) begin
      md_w.en   = 1'b1;
      md_w.idx  = REG_AW'(STATUS_REG);
      md_w.data = head[EW-2] ? DATA_W'(ST_DIV) : DATA_W'(ST_MUL);
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (pw.en) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= pw.idx;
      data_writeReg    <= pw.data;
    end else if (pop) begin
      ctrl_writeEnable <= md_w.en;
      ctrl_writeReg    <= md_w.idx;
      data_writeReg    <= md_w.data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic        clock = 1'b0, reset = 1'b1;
  logic        mw_valid = 1'b0, mw_ovf = 1'b0;
  logic [31:0] mw_insn = '0, mw_o = '0, mw_d = '0;
  logic        md_valid = 1'b0, md_exc = 1'b0, md_div = 1'b0, md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_result = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  md_count;

  wb_arbiter dut (
    .clock(clock), .reset(reset), .mw_valid(mw_valid), .mw_insn(mw_insn),
    .mw_o(mw_o), .mw_d(mw_d), .mw_ovf(mw_ovf), .md_valid(md_valid),
    .md_ready(md_ready), .md_rd(md_rd), .md_result(md_result), .md_exc(md_exc),
    .md_div(md_div), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .md_count(md_count)
  );

  always #5 clock = ~clock;

  typedef struct {logic [4:0] rd; logic [31:0] res; logic exc; logic div;} md_t;
  md_t         q[$];
  logic        exp_en;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  bit          last_push;
  int          checks = 0, errors = 0;

  // Architectural write rule of the MW stage, straight from the opcode table.
  function automatic void decode(input logic [31:0] insn, input logic [31:0] o, d,
                                 input logic ovf, output logic en,
                                 output logic [4:0] r, output logic [31:0] v);
    logic [4:0] op, rd;
    op = insn[31:27]; rd = insn[26:22];
    en = 1'b0; r = 5'd0; v = 32'd0;
    if (op == 5'b00000 || op == 5'b00101) begin en = (rd != 0); r = rd; v = o; end
    else if (op == 5'b01000)              begin en = (rd != 0); r = rd; v = d; end
    else if (op == 5'b00011)              begin en = 1'b1; r = 5'd31; v = o; end
    else if (op == 5'b10101)              begin en = 1'b1; r = 5'd30; v = o; end
`ifdef WB_EXCEPTION_EN
    if (ovf && op == 5'b00101) begin en = 1'b1; r = 5'd30; v = 32'd2; end
    else if (ovf && op == 5'b00000 && insn[6:2] == 5'd0) begin en = 1'b1; r = 5'd30; v = 32'd1; end
    else if (ovf && op == 5'b00000 && insn[6:2] == 5'd1) begin en = 1'b1; r = 5'd30; v = 32'd3; end
`else
    if (ovf === 1'bx) en = 1'bx;
`endif
  endfunction

  // Advance one clock; the model consumes the inputs currently driven.
  task automatic step();
    logic pen; logic [4:0] pr; logic [31:0] pd; md_t e, h;
    decode(mw_insn, mw_o, mw_d, mw_ovf, pen, pr, pd);
    pen = pen & mw_valid;
    last_push = md_valid && (q.size() < 4);
    e = '{md_rd, md_result, md_exc, md_div};
    @(posedge clock);
    if (pen) begin exp_en = 1'b1; exp_reg = pr; exp_data = pd; end
    else if (q.size() > 0) begin
      h = q.pop_front();
      exp_en = (h.rd != 0); exp_reg = h.rd; exp_data = h.res;
`ifdef WB_EXCEPTION_EN
      if (h.exc) begin exp_en = 1'b1; exp_reg = 5'd30; exp_data = h.div ? 32'd5 : 32'd4; end
`endif
    end else exp_en = 1'b0;
    if (last_push) q.push_back(e);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] op, rd, input logic [31:0] o, d,
                      input logic [4:0] alu = 5'd0, input logic ovf = 1'b0);
    mw_valid = v; mw_insn = {op, rd, 15'($urandom), alu, 2'b00};
    mw_o = o; mw_d = d; mw_ovf = ovf;
  endtask

  task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] r,
                    input logic exc = 1'b0, input logic div = 1'b0);
    md_valid = v; md_rd = rd; md_result = r; md_exc = exc; md_div = div;
  endtask

  task automatic test_reset();
    pipe(0, 5'b00000, 0, 0, 0); md(0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0 ||
        md_count !== 3'd0 || md_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got en=%b reg=%0d data=%h cnt=%0d rdy=%b want 0/0/0/0/1",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_count, md_ready);
    end
    @(negedge clock) reset = 1'b0;
    q.delete(); exp_en = 1'b0; exp_reg = 5'd0; exp_data = 32'd0;
    @(posedge clock); #1;
  endtask

  task automatic test_decode();
    pipe(1, OP_RTYPE, 3, 32'h12, 32'h99, ALU_ADD); step();
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h12) begin
      errors++; $display("FAIL add_r3 got %b/%0d/%h want 1/3/12", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    pipe(1, OP_LW, 7, 32'h40, 32'hDEAD); step();
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || data_writeReg !== 32'hDEAD) begin
      errors++; $display("FAIL lw_r7 got %b/%0d/%h want 1/7/dead", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    pipe(1, OP_JAL, 4, 32'h100, 32'h5); step();
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd31 || data_writeReg !== 32'h100) begin
      errors++; $display("FAIL jal got %b/%0d/%h want 1/31/100", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    pipe(1, OP_SETX, 2, 32'h77, 32'h5); step();
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd30 || data_writeReg !== 32'h77) begin
      errors++; $display("FAIL setx got %b/%0d/%h want 1/30/77", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    pipe(1, OP_RTYPE, 0, 32'h55, 32'h5, ALU_ADD); step();
    checks++;
    if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL add_r0 got en=%b want 0", ctrl_writeEnable); end
    pipe(1, 5'b00111, 6, 32'h55, 32'h5); step();
    checks++;
    if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL other_op got en=%b want 0", ctrl_writeEnable); end
    pipe(0, OP_ADDI, 5, 32'h55, 32'h5); step();
    checks++;
    if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL not_valid got en=%b want 0", ctrl_writeEnable); end
  endtask

  task automatic test_md_drain();
    pipe(1, OP_ADDI, 1, 32'h1, 0); md(1, 5, 32'd42); step();
    md(0, 0, 0);
    pipe(1, OP_ADDI, 2, 32'h2, 0); step();
    pipe(1, OP_ADDI, 3, 32'h3, 0); step();
    checks++;
    if (md_count !== 3'd1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h3) begin
      errors++; $display("FAIL md_wait got cnt=%0d reg=%0d data=%h want 1/3/3", md_count, ctrl_writeReg, data_writeReg);
    end
    pipe(0, 0, 0, 0, 0); step();
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'd42 || md_count !== 3'd0) begin
      errors++; $display("FAIL md_drain got %b/%0d/%0d cnt=%0d want 1/5/42 cnt=0",
                         ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [4:0] seen[$];
    logic [4:0] want[5];
    int n;
    want = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20};
    for (int i = 0; i < 4; i++) begin
      pipe(1, OP_ADDI, 2, i, 0); md(1, 5'(10 + i), 100 + i); step();
    end
    md(1, 20, 200);
    checks++;
    if (md_ready !== 1'b0 || md_count !== 3'd4) begin
      errors++; $display("FAIL full got rdy=%b cnt=%0d want 0/4", md_ready, md_count);
    end
    repeat (2) step();
    checks++;
    if (md_ready !== 1'b0 || md_count !== 3'd4) begin
      errors++; $display("FAIL full_hold got rdy=%b cnt=%0d want 0/4", md_ready, md_count);
    end
    pipe(0, 0, 0, 0, 0);
    n = 0;
    do begin
      step(); n++;
      if (ctrl_writeEnable) seen.push_back(ctrl_writeReg);
    end while (!last_push && n < 10);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL fifth_accept got after %0d pops want 2", n); end
    md(0, 0, 0);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      step(); n++;
      if (ctrl_writeEnable) seen.push_back(ctrl_writeReg);
    end
    checks++;
    if (seen.size() != 5) begin errors++; $display("FAIL drain_count got %0d want 5", seen.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++;
      if (seen[i] !== want[i]) begin errors++; $display("FAIL drain_order[%0d] got %0d want %0d", i, seen[i], want[i]); end
    end
  endtask

  task automatic test_rd0();
    pipe(0, 0, 0, 0, 0); md(1, 0, 32'd77); step();
    md(0, 0, 0);
    checks++;
    if (md_count !== 3'd1) begin errors++; $display("FAIL rd0_push got cnt=%0d want 1", md_count); end
    step();
    checks++;
    if (ctrl_writeEnable !== 1'b0 || md_count !== 3'd0) begin
      errors++; $display("FAIL rd0_pop got en=%b cnt=%0d want 0/0", ctrl_writeEnable, md_count);
    end
  endtask

  task automatic test_exception();
    logic [4:0] wr; logic [31:0] wd;
    pipe(1, OP_RTYPE, 9, 32'h55, 0, ALU_SUB, 1'b1); step();
`ifdef WB_EXCEPTION_EN
    wr = 5'd30; wd = 32'd3;
`else
    wr = 5'd9; wd = 32'h55;
`endif
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== wr || data_writeReg !== wd) begin
      errors++; $display("FAIL sub_ovf got %b/%0d/%h want 1/%0d/%h", ctrl_writeEnable, ctrl_writeReg, data_writeReg, wr, wd);
    end
    pipe(0, 0, 0, 0, 0); md(1, 12, 32'h999, 1'b1, 1'b1); step();
    md(0, 0, 0); step();
`ifdef WB_EXCEPTION_EN
    wr = 5'd30; wd = 32'd5;
`else
    wr = 5'd12; wd = 32'h999;
`endif
    checks++;
    if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== wr || data_writeReg !== wd) begin
      errors++; $display("FAIL md_exc got %b/%0d/%h want 1/%0d/%h", ctrl_writeEnable, ctrl_writeReg, data_writeReg, wr, wd);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      pipe(1, OP_ADDI, 4, i, 0); md(1, 5'(6 + i), 500 + i); step();
    end
    md(0, 0, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0 || md_count !== 3'd0) begin
      errors++; $display("FAIL reset_mid got %b/%0d/%h cnt=%0d want all 0",
                         ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_count);
    end
    pipe(0, 0, 0, 0, 0);
    @(negedge clock) reset = 1'b0;
    q.delete(); exp_en = 1'b0; exp_reg = 5'd0; exp_data = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_flush[%0d] got en=%b want 0", i, ctrl_writeEnable); end
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[8];
    ops = '{OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX, 5'b00111, 5'b01001, 5'b11111};
    for (int c = 0; c < 400; c++) begin
      pipe($urandom_range(0, 1), ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
           $urandom, $urandom, 5'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
      if (!md_valid || last_push)
        md($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) == 0), 1'($urandom));
      step();
      checks++;
      if (ctrl_writeEnable !== exp_en || (exp_en && (ctrl_writeReg !== exp_reg || data_writeReg !== exp_data))) begin
        errors++; $display("FAIL rand_write[%0d] got %b/%0d/%h want %b/%0d/%h", c,
                           ctrl_writeEnable, ctrl_writeReg, data_writeReg, exp_en, exp_reg, exp_data);
      end
      checks++;
      if (md_count !== 3'(q.size()) || md_ready !== (q.size() < 4)) begin
        errors++; $display("FAIL rand_count[%0d] got cnt=%0d rdy=%b want %0d", c, md_count, md_ready, q.size());
      end
    end
    md(0, 0, 0); pipe(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_md_drain();
    test_fifo_full();
    test_rd0();
    test_exception();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
